// File: rtl/temporal_fusion_mac_pkg.sv
// Shared fusion/conv package: mode and state enums plus the fixed-point helpers
// (saturate, round-half-up shift) reused across fusion and conv blocks.
package fusion_pkg;

  typedef enum logic [1:0] {
    SUM  = 2'd0,
    MEAN = 2'd1,
    MAX  = 2'd2,
    RSVD = 2'd3
  } fusion_mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    FUSE = 2'd2,
    OUT  = 2'd3
  } fusion_state_e;

  // Wide working type; callers sign-extend into it and truncate the result.
  localparam int CALC_W = 64;
  typedef logic signed [CALC_W-1:0] calc_t;

  function automatic calc_t sat_to_width(input calc_t v, input int w);
    calc_t hi;
    calc_t lo;
    hi = (calc_t'(1) <<< (w - 1)) - calc_t'(1);
    lo = -hi - calc_t'(1);
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  function automatic calc_t round_shift(input calc_t v, input int sh);
    if (sh <= 0) return v;
    return (v + (calc_t'(1) <<< (sh - 1))) >>> sh;
  endfunction

endpackage

// File: rtl/temporal_fusion_mac_if.sv
// Stream-side bus of temporal_fusion_mac: vector input, fused output, busy flag.
interface temporal_fusion_mac_if #(
  parameter int DATA_WIDTH  = 16,
  parameter int NUM_STREAMS = 4
);
  // A transfer happens on a rising edge where valid && ready; the source holds
  // data/mode stable while valid is high and ready is low.
  logic [NUM_STREAMS-1:0][DATA_WIDTH-1:0] x_in;
  logic                                   x_valid;
  logic                                   x_ready;
  logic [1:0]                             mode;
  logic [DATA_WIDTH-1:0]                  y_out;
  logic                                   y_valid;
  logic                                   y_ready;
  logic                                   busy;

  modport master (
    output x_in, x_valid, mode, y_ready,
    input  x_ready, y_out, y_valid, busy
  );

  modport slave (
    input  x_in, x_valid, mode, y_ready,
    output x_ready, y_out, y_valid, busy
  );
endinterface

// File: rtl/temporal_fusion_mac_mac_unit.sv
// Registered signed multiply-accumulate; i_clr starts a fresh sum with this product.
module mac_unit
  import fusion_pkg::*;
#(
  parameter int A_W   = 16,
  parameter int B_W   = 16,
  parameter int ACC_W = 48
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_en,
  input  logic                    i_clr,
  input  logic signed [A_W-1:0]   i_a,
  input  logic signed [B_W-1:0]   i_b,
  output logic signed [ACC_W-1:0] o_acc_next
);

  logic signed [A_W+B_W-1:0] w_prod;
  logic signed [ACC_W-1:0]   w_prod_ext;
  logic signed [ACC_W-1:0]   w_base;
  logic signed [ACC_W-1:0]   r_acc;

  assign w_prod     = i_a * i_b;
  assign w_prod_ext = ACC_W'(w_prod);
  assign w_base     = i_clr ? '0 : r_acc;
  assign o_acc_next = w_base + w_prod_ext;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= o_acc_next;
    end
  end

endmodule

// File: rtl/temporal_fusion_mac.sv
// Multi-stream FIR fusion with one time-shared MAC: walks (stream, tap) pairs,
// requantises each stream, then fuses by SUM, MEAN or MAX.
module temporal_fusion_mac
  import fusion_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int COEF_WIDTH  = 16,
  parameter int ACC_WIDTH   = 48,
  parameter int FRAC_BITS   = 14,
  parameter int KERNEL_SIZE = 5,
  parameter int NUM_STREAMS = 4,
  parameter logic signed [COEF_WIDTH-1:0] COEFFS [NUM_STREAMS][KERNEL_SIZE] = '{default: '0}
) (
  input  logic                  clk,
  input  logic                  rst_n,
  temporal_fusion_mac_if.slave  bus,
  output fusion_state_e         o_dbg_state
);

  localparam int LOG2_NS = $clog2(NUM_STREAMS);
  localparam int FUS_W   = DATA_WIDTH + LOG2_NS;
  localparam int S_W     = LOG2_NS;
  localparam int K_W     = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1;

  if (!((NUM_STREAMS >= 2) && ((NUM_STREAMS & (NUM_STREAMS - 1)) == 0))) begin : g_bad_ns
    $error("NUM_STREAMS must be a power of two and at least 2");
  end
  if (KERNEL_SIZE < 1) begin : g_bad_ks
    $error("KERNEL_SIZE must be at least 1");
  end
  if (ACC_WIDTH < DATA_WIDTH + COEF_WIDTH + $clog2(KERNEL_SIZE)) begin : g_bad_acc
    $error("ACC_WIDTH too narrow for a full kernel sum");
  end

  fusion_state_e                r_state;
  fusion_mode_e                 r_mode;
  logic [S_W-1:0]               r_s_idx;
  logic [K_W-1:0]               r_k_idx;
  logic signed [DATA_WIDTH-1:0] r_taps [NUM_STREAMS][KERNEL_SIZE];
  logic signed [FUS_W-1:0]      r_fus;
  logic [DATA_WIDTH-1:0]        r_y_out;
  logic                         r_y_valid;
  logic                         r_busy;

  logic                         w_x_ready;
  logic                         w_accept;
  logic                         w_last_tap;
  logic                         w_last_stream;
  logic signed [DATA_WIDTH-1:0] w_tap;
  logic signed [COEF_WIDTH-1:0] w_coef;
  logic signed [ACC_WIDTH-1:0]  w_acc_next;
  logic signed [DATA_WIDTH-1:0] w_r;
  logic signed [FUS_W-1:0]      w_r_ext;
  logic signed [FUS_W-1:0]      w_fus_next;
  logic [DATA_WIDTH-1:0]        w_result;

  assign w_x_ready     = (r_state == IDLE) || ((r_state == OUT) && bus.y_ready);
  assign w_accept      = bus.x_valid && w_x_ready;
  assign w_last_tap    = (r_k_idx == K_W'(KERNEL_SIZE - 1));
  assign w_last_stream = (r_s_idx == S_W'(NUM_STREAMS - 1));
  assign w_tap         = r_taps[r_s_idx][r_k_idx];
  assign w_coef        = COEFFS[r_s_idx][r_k_idx];

  mac_unit #(
    .A_W   (DATA_WIDTH),
    .B_W   (COEF_WIDTH),
    .ACC_W (ACC_WIDTH)
  ) u_mac (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_en       (r_state == MAC),
    .i_clr      (r_k_idx == '0),
    .i_a        (w_tap),
    .i_b        (w_coef),
    .o_acc_next (w_acc_next)
  );

  // Requantise from the combinational sum so the last tap needs no extra cycle.
  assign w_r     = DATA_WIDTH'(sat_to_width(round_shift(calc_t'(w_acc_next), FRAC_BITS),
                                            DATA_WIDTH));
  assign w_r_ext = FUS_W'(w_r);

  always_comb begin
    w_fus_next = r_fus;
    if (r_s_idx == '0) begin
      w_fus_next = w_r_ext;
    end else if (r_mode == MAX) begin
      w_fus_next = (w_r_ext > r_fus) ? w_r_ext : r_fus;
    end else begin
      w_fus_next = r_fus + w_r_ext;
    end
  end

  always_comb begin
    w_result = DATA_WIDTH'(sat_to_width(calc_t'(r_fus), DATA_WIDTH));
    case (r_mode)
      MEAN:    w_result = DATA_WIDTH'(r_fus >>> LOG2_NS);
      MAX:     w_result = DATA_WIDTH'(r_fus);
      default: w_result = DATA_WIDTH'(sat_to_width(calc_t'(r_fus), DATA_WIDTH));
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_mode    <= SUM;
      r_s_idx   <= '0;
      r_k_idx   <= '0;
      r_fus     <= '0;
      r_y_out   <= '0;
      r_y_valid <= 1'b0;
      r_busy    <= 1'b0;
      for (int s = 0; s < NUM_STREAMS; s++) begin
        for (int k = 0; k < KERNEL_SIZE; k++) begin
          r_taps[s][k] <= '0;
        end
      end
    end else begin
      case (r_state)
        MAC: begin
          if (w_last_tap) begin
            r_fus   <= w_fus_next;
            r_k_idx <= '0;
            if (w_last_stream) begin
              r_state <= FUSE;
            end else begin
              r_s_idx <= r_s_idx + S_W'(1);
            end
          end else begin
            r_k_idx <= r_k_idx + K_W'(1);
          end
        end
        FUSE: begin
          r_y_out   <= w_result;
          r_y_valid <= 1'b1;
          r_state   <= OUT;
        end
        OUT: begin
          if (bus.y_ready) begin
            r_y_valid <= 1'b0;
            r_state   <= IDLE;
            r_busy    <= 1'b0;
          end
        end
        default: ;
      endcase
      // Acceptance overrides the OUT->IDLE exit so back-to-back vectors skip IDLE.
      if (w_accept) begin
        for (int s = 0; s < NUM_STREAMS; s++) begin
          for (int k = KERNEL_SIZE - 1; k > 0; k--) begin
            r_taps[s][k] <= r_taps[s][k-1];
          end
          r_taps[s][0] <= bus.x_in[s];
        end
        r_mode  <= fusion_mode_e'(bus.mode);
        r_s_idx <= '0;
        r_k_idx <= '0;
        r_state <= MAC;
        r_busy  <= 1'b1;
      end
    end
  end

  assign bus.x_ready = w_x_ready;
  assign bus.y_out   = r_y_out;
  assign bus.y_valid = r_y_valid;
  assign bus.busy    = r_busy;
  assign o_dbg_state = r_state;

endmodule

// File: doc/temporal_fusion_mac.md
# temporal_fusion_mac

Multi-stream temporal fusion block with a single time-shared MAC, runtime-selectable fusion mode, and valid/ready handshakes on both sides. Each accepted input vector is pushed into a per-stream FIR delay line. The FSM then walks every (stream, tap) pair through one multiplier, requantises each stream result, and fuses the streams by SUM, MEAN or MAX. It sits between the per-channel temporal feature extractors and the classifier head, in place of the fully parallel fusion stage where multiplier count matters more than throughput.

## Interface
- DATA_WIDTH, 16: sample width, signed.
- COEF_WIDTH, 16: coefficient width, signed, FRAC_BITS fractional bits.
- ACC_WIDTH, 48: MAC accumulator width, signed.
- FRAC_BITS, 14: coefficient fractional bits.
- KERNEL_SIZE, 5: taps per stream. Must be ≥ 1.
- NUM_STREAMS, 4: stream count. Must be a power of two, ≥ 2.
- COEFFS, all 0: signed [COEF_WIDTH] array [NUM_STREAMS][KERNEL_SIZE]. Index 0 is the newest-sample tap.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- x_in  in  DATA_WIDTH × NUM_STREAMS  input vector, one sample per stream.
- x_valid  in  1  input vector valid.
- x_ready  out  1  block can accept a vector.
- mode  in  2  fusion mode: 0 SUM, 1 MEAN, 2 MAX, 3 reserved (behaves as SUM). Sampled only on input acceptance.
- y_out  out  DATA_WIDTH  fused sample.
- y_valid  out  1  y_out valid.
- y_ready  in  1  downstream accepts y_out.
- busy  out  1  high in every state except IDLE.

## Operation
- **FSM states:** IDLE, MAC, FUSE, OUT.
- **Input acceptance:** a vector is accepted when x_valid && x_ready. x_ready = (IDLE) || (OUT && y_ready), combinational.
- **On accept:**
  - Every delay line shifts by one; x_in[s] enters tap 0.
  - mode is latched.
  - Stream and tap indices clear.
  - FSM enters MAC.
- **MAC:** one product per cycle, COEFFS[s][k] × tap[s][k]. Tap k runs fastest, then stream s. The accumulator clears at the start of each stream.
- **Per-stream requantisation** (applied on the last tap of each stream, same cycle):
  - r = (acc + 2^(FRAC_BITS-1)) >>> FRAC_BITS, arithmetic shift, round half up.
  - r saturates to the DATA_WIDTH signed range.
- **Fusion register:** width DATA_WIDTH + log2(NUM_STREAMS).
  - SUM/MEAN: the register accumulates r.
  - MAX: the register takes the first stream's r, then the signed max against each later r.
- **Leaving MAC:** after NUM_STREAMS × KERNEL_SIZE cycles the FSM moves to FUSE.
- **FUSE:**
  - SUM: saturate the fusion register to DATA_WIDTH.
  - MEAN: fusion register >>> log2(NUM_STREAMS), arithmetic shift, floor.
  - MAX: pass the value through.
  - The result registers into y_out; FSM goes to OUT.
- **OUT:** y_valid is high. y_out is held stable until y_ready.
  - Handshake with no simultaneous accept → IDLE.
  - Handshake with a simultaneous accept → MAC directly, no bubble.
- **Reset:**
  - Reset values: state IDLE, y_out 0, y_valid 0, busy 0, all delay lines 0, accumulator and fusion register 0, latched mode SUM.
  - A reset asserted mid-MAC or mid-OUT discards the in-flight result and clears all history.
- **Illegal inputs:** x_valid while not ready is ignored; the source must hold. mode changes outside acceptance have no effect.

## Timing
- Acceptance edge E0 is followed by NUM_STREAMS × KERNEL_SIZE MAC cycles and one FUSE cycle.
- y_valid rises after edge E0 + NUM_STREAMS × KERNEL_SIZE + 1. With defaults this is 21 cycles.
- **Throughput:** one vector per NUM_STREAMS × KERNEL_SIZE + 2 cycles when y_ready is held high.
- **Output registers:** y_out and y_valid are registered. Only x_ready is combinational.
- **Latency** is independent of mode.

## Structure
- **Shared package `fusion_pkg`:**
  - `fusion_mode_e`: SUM, MEAN, MAX, RSVD.
  - `fusion_state_e`.
  - Helper functions `sat_to_width` and `round_shift`, reused by other fusion and conv blocks.
- **Sub-module `mac_unit`:** a registered signed multiply-accumulate with a clear input, instantiated once.
- **Elaboration checks:**
  - NUM_STREAMS is a power of two.
  - KERNEL_SIZE ≥ 1.
  - ACC_WIDTH ≥ DATA_WIDTH + COEF_WIDTH + $clog2(KERNEL_SIZE).

## Test plan
All scenarios use default parameters.
- **Identity taps, all modes.** COEFFS[s][0] = 16384, other taps 0; x_in = {100, 200, 300, 400}.
  - SUM → 1000; MEAN → 250; MAX → 400.
  - y_valid appears exactly 21 cycles after accept.
- **Saturation and signed MAX.**
  - Identity taps, x_in all 32767, SUM → 32767.
  - x_in = {-100, -200, -300, -400}, MAX → -100.
  - Same input, MEAN → -250.
- **Delay line.** COEFFS[s][1] = 16384 only.
  - First vector {5, 5, 5, 5}, SUM → 0.
  - Second vector {9, 9, 9, 9}, SUM → 20.
- **Rounding.** COEFFS[0][0] = 8192 (0.5), other coefficients 0; x_in[0] = 3, SUM → 2. x_in[0] = -3, SUM → -1.
- **Backpressure.**
  - Hold y_ready low for 10 cycles: y_out stays stable, x_ready stays 0.
  - Then raise y_ready with x_valid high: both handshakes occur in the same cycle, and the next y_valid follows 21 cycles later.
- **Reset mid-MAC.** Assert rst_n low at MAC cycle 7:
  - All outputs go to reset values immediately.
  - After release, an identity SUM of {1, 1, 1, 1} → 4, proving history was cleared.
